// File: rtl/cam_pkg.sv
// Shared encodings for the CAM entry-management front end.
package cam_pkg;

  localparam logic CAM_OP_INSERT = 1'b0;
  localparam logic CAM_OP_DELETE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALLOC,
    ST_WRITE,
    ST_RESP
  } cam_upd_state_t;

endpackage

// File: rtl/cam_free_pe.sv
// Lowest-set-bit priority encoder; fed with the inverted valid bitmap it
// yields the lowest free CAM address.
module cam_free_pe #(
  parameter int N  = 64,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cam_update_ctrl.sv
// Insert/delete front end for the CAM write port: allocates the lowest free
// address, holds the write bus for WR_CYCLES, then returns address and status.
module cam_update_ctrl
  import cam_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 36,
  parameter int KBW       = 16,
  parameter int WR_CYCLES = 64,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [AW-1:0]              req_addr,
  input  logic [WIDTH-1:0]           req_patt,
  input  logic [WIDTH-1:0]           req_mask,
  input  logic [KBW-1:0]             req_kbit,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_ok,
  output logic [AW-1:0]              rsp_addr,
  output logic                       cam_wEn,
  output logic [AW-1:0]              cam_wAddr,
  output logic [WIDTH-1:0]           cam_wPatt,
  output logic [WIDTH-1:0]           cam_wMask,
  output logic [KBW-1:0]             cam_wKbit,
  output logic                       cam_busy,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt
);

  localparam int FCW = $clog2(DEPTH + 1);
  localparam int CW  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  cam_upd_state_t r_state, w_state_nxt;

  logic             r_op;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_patt, r_mask;
  logic [KBW-1:0]   r_kbit;
  logic [DEPTH-1:0] r_bitmap;
  logic [FCW-1:0]   r_free_cnt;
  logic [CW-1:0]    r_cnt;
  logic             r_wen, r_busy, r_rsp_valid, r_rsp_ok;
  logic [AW-1:0]    r_rsp_addr, r_waddr;
  logic [WIDTH-1:0] r_wpatt, r_wmask;
  logic [KBW-1:0]   r_wkbit;

  logic          w_req_hs, w_rsp_hs, w_free_found, w_del_hit, w_alloc_ok, w_wr_done, w_wen_nxt;
  logic [AW-1:0] w_free_idx;

  cam_free_pe #(.N(DEPTH), .IW(AW)) u_free_pe (
    .vec   (~r_bitmap),
    .found (w_free_found),
    .idx   (w_free_idx)
  );

  assign req_ready  = (r_state == ST_IDLE) && !rst;
  assign w_req_hs   = req_valid && req_ready;
  assign w_rsp_hs   = r_rsp_valid && rsp_ready;
  assign w_del_hit  = (32'(r_addr) < DEPTH) && r_bitmap[r_addr];
  assign w_alloc_ok = (r_op == CAM_OP_INSERT) ? w_free_found : w_del_hit;
  assign w_wr_done  = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_req_hs) w_state_nxt = ST_ALLOC;
      ST_ALLOC: w_state_nxt = w_alloc_ok ? ST_WRITE : ST_RESP;
      ST_WRITE: if (w_wr_done) w_state_nxt = ST_RESP;
      ST_RESP:  if (w_rsp_hs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_wen_nxt = (w_state_nxt == ST_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the bitmap is reset because allocation trusts it; CAM contents are not scrubbed.
      r_bitmap    <= '0;
      r_free_cnt  <= FCW'(DEPTH);
      r_op        <= CAM_OP_INSERT;
      r_addr      <= '0;
      r_patt      <= '0;
      r_mask      <= '0;
      r_kbit      <= '0;
      r_cnt       <= '0;
      r_wen       <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_ok    <= 1'b0;
      r_rsp_addr  <= '0;
      r_waddr     <= '0;
      r_wpatt     <= '0;
      r_wmask     <= '0;
      r_wkbit     <= '0;
    end else begin
      r_wen       <= w_wen_nxt;
      // Busy covers the write plus one cycle for the CAM's read-after-write update.
      r_busy      <= w_wen_nxt | r_wen;
      r_rsp_valid <= (w_state_nxt == ST_RESP);

      if (w_req_hs) begin
        r_op   <= req_op;
        r_addr <= req_addr;
        r_patt <= req_patt;
        r_mask <= req_mask;
        r_kbit <= req_kbit;
      end

      unique case (r_state)
        ST_ALLOC: begin
          if (!w_alloc_ok) begin
            r_rsp_ok   <= 1'b0;
            r_rsp_addr <= '0;
          end else if (r_op == CAM_OP_INSERT) begin
            r_bitmap[w_free_idx] <= 1'b1;
            r_free_cnt <= r_free_cnt - FCW'(1);
            r_waddr    <= w_free_idx;
            r_wpatt    <= r_patt;
            r_wmask    <= r_mask;
            r_wkbit    <= r_kbit;
            r_cnt      <= CW'(WR_CYCLES - 1);
          end else begin
            r_bitmap[r_addr] <= 1'b0;
            r_free_cnt <= r_free_cnt + FCW'(1);
            r_waddr    <= r_addr;
            r_wpatt    <= '0;
            r_wmask    <= '0;
            r_wkbit    <= '0;
            r_cnt      <= CW'(WR_CYCLES - 1);
          end
        end
        ST_WRITE: begin
          if (!w_wr_done) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_rsp_ok   <= 1'b1;
            r_rsp_addr <= r_waddr;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_ok    = r_rsp_ok;
  assign rsp_addr  = r_rsp_addr;
  assign cam_wEn   = r_wen;
  assign cam_wAddr = r_waddr;
  assign cam_wPatt = r_wpatt;
  assign cam_wMask = r_wmask;
  assign cam_wKbit = r_wkbit;
  assign cam_busy  = r_busy;
  assign free_cnt  = r_free_cnt;

endmodule

// File: tb/tb_cam_update_ctrl.sv
// Directed self-checking bench for cam_update_ctrl with hand-computed expectations.
module tb_cam_update_ctrl;

  localparam int DEPTH = 64;
  localparam int WIDTH = 36;
  localparam int KBW   = 16;
  localparam int WR    = 64;
  localparam int AW    = 6;
  localparam int FCW   = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_op;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_patt, req_mask;
  logic [KBW-1:0]   req_kbit;
  logic             rsp_valid, rsp_ready, rsp_ok;
  logic [AW-1:0]    rsp_addr;
  logic             cam_wEn, cam_busy;
  logic [AW-1:0]    cam_wAddr;
  logic [WIDTH-1:0] cam_wPatt, cam_wMask;
  logic [KBW-1:0]   cam_wKbit;
  logic [FCW-1:0]   free_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] obs_patt, obs_mask, or_patt, or_mask;
  logic [KBW-1:0]   obs_kbit, or_kbit;
  logic [AW-1:0]    obs_waddr;
  logic             busy_mid, busy_after;

  always #5 clk = ~clk;

  cam_update_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .KBW(KBW), .WR_CYCLES(WR), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_patt(req_patt), .req_mask(req_mask), .req_kbit(req_kbit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok), .rsp_addr(rsp_addr),
    .cam_wEn(cam_wEn), .cam_wAddr(cam_wAddr), .cam_wPatt(cam_wPatt),
    .cam_wMask(cam_wMask), .cam_wKbit(cam_wKbit),
    .cam_busy(cam_busy), .free_cnt(free_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request: handshake, scramble inputs, wait for the response, optionally consume it.
  // lat counts rising edges from the request handshake to the edge that raised rsp_valid.
  task automatic do_op(input logic op, input logic [AW-1:0] addr, input logic [WIDTH-1:0] patt,
                       input logic [WIDTH-1:0] mask, input logic [KBW-1:0] kbit, input bit consume,
                       output logic ok, output logic [AW-1:0] raddr, output int lat, output int wen);
    bit got;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    req_patt = patt; req_mask = mask; req_kbit = kbit;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~addr; req_patt = ~patt; req_mask = ~mask; req_kbit = ~kbit;
    lat = 0; wen = 0; got = 1'b0; ok = 1'b0; raddr = '0;
    or_patt = '0; or_mask = '0; or_kbit = '0; busy_mid = 1'b0; busy_after = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (cam_wEn) begin
        wen++;
        or_patt |= cam_wPatt; or_mask |= cam_wMask; or_kbit |= cam_wKbit;
        obs_patt = cam_wPatt; obs_mask = cam_wMask; obs_kbit = cam_wKbit; obs_waddr = cam_wAddr;
        if (wen == WR / 2) busy_mid = cam_busy;
      end
      if (rsp_valid) begin
        got = 1'b1; busy_after = cam_busy; ok = rsp_ok; raddr = rsp_addr;
      end
    end
    if (!got) check("rsp_timeout", 64'(got), 64'(1));
    if (consume) @(negedge clk);
  endtask

  initial begin
    logic          ok;
    logic [AW-1:0] ra;
    int            lat, wen;
    logic [WIDTH-1:0] patt_tab [3];
    patt_tab[0] = 36'h1234; patt_tab[1] = 36'h5678; patt_tab[2] = 36'h9abc;

    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
    req_patt = '0; req_mask = '0; req_kbit = '0; rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_ok",    64'(rsp_ok),    64'(0));
    check("rst_rsp_addr",  64'(rsp_addr),  64'(0));
    check("rst_wen",       64'(cam_wEn),   64'(0));
    check("rst_wpatt",     64'(cam_wPatt), 64'(0));
    check("rst_busy",      64'(cam_busy),  64'(0));
    check("rst_free_cnt",  64'(free_cnt),  64'(64));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'(1));

    // Three inserts land at 0, 1, 2
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 6'd0, patt_tab[i], '0, 16'h0001, 1'b1, ok, ra, lat, wen);
      check("ins_ok",    64'(ok),        64'(1));
      check("ins_addr",  64'(ra),        64'(i));
      check("ins_wen",   64'(wen),       64'(WR));
      check("ins_lat",   64'(lat),       64'(WR + 1));
      check("ins_patt",  64'(obs_patt),  64'(patt_tab[i]));
      check("ins_mask",  64'(obs_mask),  64'(0));
      check("ins_kbit",  64'(obs_kbit),  64'(16'h0001));
      check("ins_waddr", 64'(obs_waddr), 64'(i));
      check("ins_busy_mid",   64'(busy_mid),   64'(1));
      check("ins_busy_after", 64'(busy_after), 64'(1));
    end
    check("free_after_3", 64'(free_cnt), 64'(61));
    check("ready_after_rsp", 64'(req_ready), 64'(1));

    // Delete 1 writes zeros, then the next insert reuses address 1
    do_op(1'b1, 6'd1, 36'hfff, 36'hfff, 16'hffff, 1'b1, ok, ra, lat, wen);
    check("del_ok",    64'(ok),        64'(1));
    check("del_addr",  64'(ra),        64'(1));
    check("del_wen",   64'(wen),       64'(WR));
    check("del_waddr", 64'(obs_waddr), 64'(1));
    check("del_patt0", 64'(or_patt),   64'(0));
    check("del_mask0", 64'(or_mask),   64'(0));
    check("del_kbit0", 64'(or_kbit),   64'(0));
    check("del_free",  64'(free_cnt),  64'(62));
    do_op(1'b0, 6'd40, 36'hdef0, 36'h00f, 16'h0003, 1'b1, ok, ra, lat, wen);
    check("reuse_ok",   64'(ok),       64'(1));
    check("reuse_addr", 64'(ra),       64'(1));
    check("reuse_mask", 64'(obs_mask), 64'(36'h00f));
    check("reuse_free", 64'(free_cnt), 64'(61));

    // Delete of an unallocated address fails without a write
    do_op(1'b1, 6'd5, '0, '0, '0, 1'b1, ok, ra, lat, wen);
    check("del5_ok",   64'(ok),       64'(0));
    check("del5_addr", 64'(ra),       64'(0));
    check("del5_wen",  64'(wen),      64'(0));
    check("del5_lat",  64'(lat),      64'(1));
    check("del5_busy", 64'(busy_after), 64'(0));
    check("del5_free", 64'(free_cnt), 64'(61));

    // Fill from empty, then overflow
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("refill_free_start", 64'(free_cnt), 64'(64));
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1'b0, '0, 36'(i + 100), '0, 16'h0001, 1'b1, ok, ra, lat, wen);
      check("fill_ok",   64'(ok), 64'(1));
      check("fill_addr", 64'(ra), 64'(i));
    end
    check("fill_wen_last", 64'(wen), 64'(WR));
    check("full_free", 64'(free_cnt), 64'(0));
    do_op(1'b0, '0, 36'h777, '0, 16'h0001, 1'b1, ok, ra, lat, wen);
    check("ovf_ok",   64'(ok),       64'(0));
    check("ovf_addr", 64'(ra),       64'(0));
    check("ovf_wen",  64'(wen),      64'(0));
    check("ovf_lat",  64'(lat),      64'(1));
    check("ovf_free", 64'(free_cnt), 64'(0));

    // Response backpressure: delete 10 with rsp_ready low, competing request held
    rsp_ready = 1'b0;
    do_op(1'b1, 6'd10, '0, '0, '0, 1'b0, ok, ra, lat, wen);
    check("bp_ok",   64'(ok), 64'(1));
    check("bp_addr", 64'(ra), 64'(10));
    req_valid = 1'b1; req_op = 1'b0; req_patt = 36'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      check("bp_req_ready", 64'(req_ready), 64'(0));
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released_valid", 64'(rsp_valid), 64'(0));
    check("bp_released_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    check("bp_not_accepted_free", 64'(free_cnt), 64'(1));
    check("bp_not_accepted_wen",  64'(cam_wEn),  64'(0));

    // Reset in the middle of a write
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_patt = 36'habc; req_kbit = 16'h0001;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_wen",   64'(cam_wEn),   64'(1));
    check("mid_waddr", 64'(cam_wAddr), 64'(10));
    check("mid_free",  64'(free_cnt),  64'(0));
    #2 rst = 1'b1;
    #1;
    check("async_wen_drop",  64'(cam_wEn),   64'(0));
    check("async_busy_drop", 64'(cam_busy),  64'(0));
    check("async_free",      64'(free_cnt),  64'(64));
    check("async_req_ready", 64'(req_ready), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rel_req_ready", 64'(req_ready), 64'(1));
    check("rel_free",      64'(free_cnt),  64'(64));

    do_op(1'b0, '0, 36'h3c3c, '0, 16'h0002, 1'b1, ok, ra, lat, wen);
    check("post_rst_ins_ok",   64'(ok),       64'(1));
    check("post_rst_ins_addr", 64'(ra),       64'(0));
    check("post_rst_ins_free", 64'(free_cnt), 64'(63));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
